// File: rtl/alu_arbiter_if.sv
// Request/response and ALU bus between the two requesters, the shared ALU and
// the alu_arbiter. The master side is the requesters plus the ALU.
interface alu_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int FW    = 5
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [FW-1:0]    req0_f;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_s;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [FW-1:0]    req1_f;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_s;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [FW-1:0]    alu_f;
   logic [WIDTH-1:0] alu_s;

   modport master (
      output req0_valid, req0_a, req0_b, req0_f, rsp0_ready,
      output req1_valid, req1_a, req1_b, req1_f, rsp1_ready,
      output alu_s,
      input  req0_ready, rsp0_valid, rsp0_s,
      input  req1_ready, rsp1_valid, rsp1_s,
      input  alu_a, alu_b, alu_f
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_f, rsp0_ready,
      input  req1_valid, req1_a, req1_b, req1_f, rsp1_ready,
      input  alu_s,
      output req0_ready, rsp0_valid, rsp0_s,
      output req1_ready, rsp1_valid, rsp1_s,
      output alu_a, alu_b, alu_f
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win a tie.
module alu_arbiter #(
   parameter int WIDTH = 16,
   parameter int FW    = 5
) (
   input logic         clk,
   input logic         rst,
   alu_arbiter_if.slave bus
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [FW-1:0]    op_f;
   logic             owner;
   logic             last_grant;
   logic             rsp0_valid_q;
   logic             rsp1_valid_q;
   logic [WIDTH-1:0] rsp0_s_q;
   logic [WIDTH-1:0] rsp1_s_q;

   logic             gnt_valid;
   logic             gnt_id;
   logic             owner_ready;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      if (state == IDLE && !rst) begin
         if (bus.req0_valid && bus.req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = FIXED_PRIO ? 1'b0 : ~last_grant;
         end else if (bus.req0_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
         end else if (bus.req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
         end
      end
   end

   assign bus.req0_ready = gnt_valid & ~gnt_id;
   assign bus.req1_ready = gnt_valid &  gnt_id;
   assign owner_ready    = owner ? bus.rsp1_ready : bus.rsp0_ready;

   // The ALU only ever sees registered operands, never the request ports.
   assign bus.alu_a = op_a;
   assign bus.alu_b = op_b;
   assign bus.alu_f = op_f;

   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_s     = rsp0_s_q;
   assign bus.rsp1_s     = rsp1_s_q;

   // NOTE: reset is synchronous, so it sits inside the clocked block and is
   // tested first; it therefore overrides any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         op_a         <= '0;
         op_b         <= '0;
         op_f         <= '0;
         owner        <= 1'b0;
         last_grant   <= 1'b1;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_s_q     <= '0;
         rsp1_s_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register
         // samples pre-edge values regardless of statement order.
         unique case (state)
            IDLE: begin
               if (gnt_valid) begin
                  op_a       <= gnt_id ? bus.req1_a : bus.req0_a;
                  op_b       <= gnt_id ? bus.req1_b : bus.req0_b;
                  op_f       <= gnt_id ? bus.req1_f : bus.req0_f;
                  owner      <= gnt_id;
                  last_grant <= gnt_id;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               // Result is captured straight into the owner's response
               // register, which then holds it after the handshake.
               if (owner) begin
                  rsp1_s_q     <= bus.alu_s;
                  rsp1_valid_q <= 1'b1;
               end else begin
                  rsp0_s_q     <= bus.alu_s;
                  rsp0_valid_q <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               if (owner_ready) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed reset/contention/backpressure
// steps followed by randomized transactions against a behavioural model.
module tb_alu_arbiter;
   localparam int WIDTH = 16;
   localparam int FW    = 5;

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(WIDTH), .FW(FW)) bus ();

   alu_arbiter #(.WIDTH(WIDTH), .FW(FW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int               n_pass   = 0;
   int               n_checks = 0;
   int               rr_last;
   logic [WIDTH-1:0] exp_s [2];

   // Stand-in for the shared ALU; the arbiter never decodes f.
   function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [FW-1:0] f);
      case (f)
         5'b00000: return a + b;
         5'b00010: return a * b;
         5'b00100: return a >> b[3:0];
         5'b01000: return a & b;
         5'b01100: return (a >= b) ? 16'd1 : 16'd0;
         5'b10010: return ~a;
         default:  return a ^ b;
      endcase
   endfunction

   assign bus.alu_s = alu_ref(bus.alu_a, bus.alu_b, bus.alu_f);

   function automatic int pick(input bit v0, input bit v1);
      if (v0 && v1) return FIXED ? 0 : 1 - rr_last;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Starts just after a rising edge with the DUT in IDLE and returns the same way.
   task automatic run_txn(input bit v0, input bit v1,
                          input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                          input logic [FW-1:0] f0,
                          input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                          input logic [FW-1:0] f1, input int stall);
      int               w;
      int               o;
      logic [WIDTH-1:0] ea, eb, es;
      logic [FW-1:0]    ef;
      bus.req0_valid = v0;
      bus.req0_a     = a0;
      bus.req0_b     = b0;
      bus.req0_f     = f0;
      bus.req1_valid = v1;
      bus.req1_a     = a1;
      bus.req1_b     = b1;
      bus.req1_f     = f1;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      w = pick(v0, v1);

      @(negedge clk);
      check("idle_req0_ready", 32'(bus.req0_ready), 32'(w == 0));
      check("idle_req1_ready", 32'(bus.req1_ready), 32'(w == 1));
      check("idle_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      check("idle_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      check("idle_rsp0_s_hold", 32'(bus.rsp0_s), 32'(exp_s[0]));
      check("idle_rsp1_s_hold", 32'(bus.rsp1_s), 32'(exp_s[1]));
      if (w < 0) begin
         @(posedge clk); #1;
         return;
      end

      o  = 1 - w;
      ea = (w == 1) ? a1 : a0;
      eb = (w == 1) ? b1 : b0;
      ef = (w == 1) ? f1 : f0;
      es = alu_ref(ea, eb, ef);

      @(posedge clk); #1;
      @(negedge clk);
      check("exec_alu_a", 32'(bus.alu_a), 32'(ea));
      check("exec_alu_b", 32'(bus.alu_b), 32'(eb));
      check("exec_alu_f", 32'(bus.alu_f), 32'(ef));
      check("exec_req0_ready", 32'(bus.req0_ready), 32'd0);
      check("exec_req1_ready", 32'(bus.req1_ready), 32'd0);
      check("exec_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);

      @(posedge clk); #1;
      rr_last  = w;
      exp_s[w] = es;
      // The non-owner's ready is raised throughout RESP and must be ignored.
      if (o == 0) bus.rsp0_ready = 1'b1;
      else        bus.rsp1_ready = 1'b1;
      for (int k = 0; k <= stall; k++) begin
         if (k == stall) begin
            if (w == 0) bus.rsp0_ready = 1'b1;
            else        bus.rsp1_ready = 1'b1;
         end
         @(negedge clk);
         check("resp_owner_valid", 32'(w == 0 ? bus.rsp0_valid : bus.rsp1_valid), 32'd1);
         check("resp_other_valid", 32'(o == 0 ? bus.rsp0_valid : bus.rsp1_valid), 32'd0);
         check("resp_owner_s", 32'(w == 0 ? bus.rsp0_s : bus.rsp1_s), 32'(es));
         check("resp_other_s", 32'(o == 0 ? bus.rsp0_s : bus.rsp1_s), 32'(exp_s[o]));
         check("resp_req_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
         @(posedge clk); #1;
      end
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
   endtask

   logic [FW-1:0] fcodes [7];

   initial begin
      fcodes[0] = 5'b00000;
      fcodes[1] = 5'b00010;
      fcodes[2] = 5'b00100;
      fcodes[3] = 5'b01000;
      fcodes[4] = 5'b01100;
      fcodes[5] = 5'b10010;
      fcodes[6] = 5'b10111;

      // Reset held with both requesters valid.
      rst            = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_a     = 16'h1111;
      bus.req0_b     = 16'h2222;
      bus.req0_f     = 5'b00000;
      bus.req1_a     = 16'h3333;
      bus.req1_b     = 16'h4444;
      bus.req1_f     = 5'b01000;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      rr_last        = 1;
      exp_s[0]       = '0;
      exp_s[1]       = '0;
      repeat (2) begin
         @(negedge clk);
         check("rst_req_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
         check("rst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
         check("rst_alu", 32'({bus.alu_f, bus.alu_b, bus.alu_a} != 0), 32'd0);
         check("rst_rsp_s", 32'({bus.rsp1_s, bus.rsp0_s}), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Contention: first tie to req0, then strict alternation.
      repeat (4)
         run_txn(1, 1, 16'h000A, 16'h0100, 5'b00010, 16'h1010, 16'hFFFF, 5'b01000, 0);

      // Single op from req0.
      run_txn(1, 0, 16'h0000, 16'h1234, 5'b00000, 16'h0, 16'h0, 5'b0, 0);

      // Backpressure on req1 with req0 still valid, then req0 accepted next.
      run_txn(1, 1, 16'h00F0, 16'h0004, 5'b00100, 16'h5A5A, 16'h00FF, 5'b10010, 5);
      run_txn(1, 0, 16'h8000, 16'h7FFF, 5'b01100, 16'h0, 16'h0, 5'b0, 1);

      // Reset during EXEC drops the op and restores the tie pointer.
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b0;
      bus.req0_a     = 16'hBEEF;
      bus.req0_b     = 16'h00FF;
      bus.req0_f     = 5'b11111;
      @(posedge clk); #1;
      rst            = 1'b1;
      bus.req1_valid = 1'b1;
      @(negedge clk);
      check("midrst_exec_alu_a", 32'(bus.alu_a), 32'h0000BEEF);
      check("midrst_req_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      @(posedge clk); #1;
      rst            = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      rr_last        = 1;
      exp_s[0]       = '0;
      exp_s[1]       = '0;
      repeat (2) begin
         @(negedge clk);
         check("midrst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
         check("midrst_alu", 32'({bus.alu_f, bus.alu_b, bus.alu_a} != 0), 32'd0);
         check("midrst_rsp_s", 32'({bus.rsp1_s, bus.rsp0_s}), 32'd0);
         @(posedge clk); #1;
      end
      run_txn(1, 1, 16'h0003, 16'h0004, 5'b00000, 16'h0007, 16'h0008, 5'b00010, 0);

      // Randomized traffic, including idle cycles and unknown function codes.
      for (int i = 0; i < 30; i++) begin
         run_txn(1'($urandom), 1'($urandom),
                 16'($urandom), 16'($urandom), fcodes[$urandom_range(0, 6)],
                 16'($urandom), 16'($urandom), fcodes[$urandom_range(0, 6)],
                 int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
